// File: rtl/wb_stream_pkg.sv
// Shared constants and helpers for the Wishbone stream-write path.
// Holds the default idle timeout and the FIFO capacity function.
// Also used by the controller's burst-size checks.
package wb_stream_pkg;

  localparam int WB_STREAM_TIMEOUT_DEFAULT = 256;

  // Usable FIFO capacity for a given address width: one slot stays empty.
  function automatic int unsigned fifo_cap(input int unsigned aw);
    return (32'd1 << aw) - 32'd1;
  endfunction

endpackage

// File: rtl/wb_stream_fifo_mem.sv
// Simple dual-port storage array for wb_stream_fifo.
// Writes are synchronous and reads are asynchronous (combinational).
// There is no flow control here; the parent decides when to write.
module wb_stream_fifo_mem #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [2**AW];

  // Write port: store the word at waddr when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/wb_stream_fifo.sv
// Show-ahead FIFO feeding the Wishbone stream-write controller.
// Push/pop visible one edge later; head word presented with no output register.
// ready deasserts at CAP; optional idle timeout is enabled by WB_STREAM_FIFO_TIMEOUT_EN.
module wb_stream_fifo
  import wb_stream_pkg::*;
#(
  parameter int WB_DW          = 32,
  parameter int FIFO_AW        = 4,
  parameter int TIMEOUT_CYCLES = WB_STREAM_TIMEOUT_DEFAULT
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n_i,
  input  logic               clr,
  input  logic [WB_DW-1:0]   stream_s_data_i,
  input  logic               stream_s_valid_i,
  output logic               stream_s_ready_o,
  output logic [WB_DW-1:0]   fifo_d,
  output logic               fifo_dv,
  output logic [FIFO_AW-1:0] fifo_cnt,
  input  logic               fifo_rd,
  output logic               fifo_timeout
);

  localparam logic [FIFO_AW-1:0] CAP = FIFO_AW'(fifo_cap(FIFO_AW));

  logic [FIFO_AW-1:0] wr_ptr_d, wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_d, rd_ptr_q;
  logic [FIFO_AW-1:0] cnt_d, cnt_q;
  logic               ready_d, ready_q;
  logic               dv_d, dv_q;
  logic               push, pop;

  assign push = stream_s_valid_i & ready_q;
  assign pop  = fifo_rd & dv_q;

  // Next pointers, count and flags; flush discards any same-cycle push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    ready_d = (cnt_d < CAP);
    dv_d    = (cnt_d != '0);
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ready_d  = 1'b0;
      dv_d     = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      dv_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      dv_q     <= dv_d;
    end
  end

  wb_stream_fifo_mem #(
    .DW (WB_DW),
    .AW (FIFO_AW)
  ) u_mem (
    .clk   (wb_clk_i),
    .we    (push & ~clr),
    .waddr (wr_ptr_q),
    .wdata (stream_s_data_i),
    .raddr (rd_ptr_q),
    .rdata (fifo_d)
  );

  assign stream_s_ready_o = ready_q;
  assign fifo_dv          = dv_q;
  assign fifo_cnt         = cnt_q;

`ifdef WB_STREAM_FIFO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] idle_d, idle_q;
  logic          timeout_d, timeout_q;

  // Idle counter: runs only while partially filled with no push, saturating.
  always_comb begin
    idle_d = idle_q;
    if (clr || push || (cnt_q == '0) || (cnt_q == CAP)) begin
      idle_d = '0;
    end else if (idle_q != TMAX) begin
      idle_d = idle_q + 1'b1;
    end
    timeout_d = (idle_d == TMAX) && (cnt_d != '0);
  end

  // Timeout registers with synchronous active-low reset.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end

  assign fifo_timeout = timeout_q;
`else
  assign fifo_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_wb_stream_fifo.sv
// Directed bench for wb_stream_fifo with FIFO_AW=4 (CAP=15), TIMEOUT_CYCLES=8.
// Inputs change 1ns after the rising edge; outputs are checked at the same point.
// Expected values are hand-derived constants and a small expected-order queue.
module tb_wb_stream_fifo;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] f_d;
  logic        f_dv;
  logic [3:0]  f_cnt;
  logic        f_rd;
  logic        f_timeout;

  int errors = 0;
  int checks = 0;

  wb_stream_fifo #(
    .WB_DW          (32),
    .FIFO_AW        (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .wb_clk_i         (clk),
    .wb_rst_n_i       (rst_n),
    .clr              (clr),
    .stream_s_data_i  (s_data),
    .stream_s_valid_i (s_valid),
    .stream_s_ready_o (s_ready),
    .fifo_d           (f_d),
    .fifo_dv          (f_dv),
    .fifo_cnt         (f_cnt),
    .fifo_rd          (f_rd),
    .fifo_timeout     (f_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_q[$];
    logic [31:0] prev;

    rst_n   = 1'b0;
    clr     = 1'b0;
    s_data  = '0;
    s_valid = 1'b0;
    f_rd    = 1'b0;

    // Reset state
    step();
    step();
    check("rst_ready", {31'd0, s_ready}, 32'd0);
    check("rst_dv", {31'd0, f_dv}, 32'd0);
    check("rst_cnt", {28'd0, f_cnt}, 32'd0);
    check("rst_timeout", {31'd0, f_timeout}, 32'd0);

    // First cycle after reset release
    rst_n = 1'b1;
    step();
    check("rel_ready", {31'd0, s_ready}, 32'd1);
    check("rel_dv", {31'd0, f_dv}, 32'd0);
    check("rel_cnt", {28'd0, f_cnt}, 32'd0);

    // Popping an empty FIFO is ignored
    f_rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("empty_rd_cnt", {28'd0, f_cnt}, 32'd0);
      check("empty_rd_dv", {31'd0, f_dv}, 32'd0);
    end
    f_rd = 1'b0;

    // Fill to capacity with 0x1..0xF
    s_valid = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      s_data = 32'(i);
      step();
      check("fill_cnt", {28'd0, f_cnt}, 32'(i));
    end
    check("full_ready", {31'd0, s_ready}, 32'd0);
    check("full_dv", {31'd0, f_dv}, 32'd1);
    check("full_head", f_d, 32'h1);

    // A 16th word must not be accepted
    s_data = 32'h16;
    step();
    step();
    check("full_hold_cnt", {28'd0, f_cnt}, 32'd15);
    check("full_hold_ready", {31'd0, s_ready}, 32'd0);
    s_valid = 1'b0;

    // Pop at CAP, ready returns the next cycle
    f_rd = 1'b1;
    step();
    f_rd = 1'b0;
    check("pop_at_cap_cnt", {28'd0, f_cnt}, 32'd14);
    check("pop_at_cap_ready", {31'd0, s_ready}, 32'd1);
    check("pop_at_cap_head", f_d, 32'h2);

    s_valid = 1'b1;
    s_data  = 32'h10;
    step();
    s_valid = 1'b0;
    check("refill_cnt", {28'd0, f_cnt}, 32'd15);
    check("refill_ready", {31'd0, s_ready}, 32'd0);

    // Drain and check order 0x2..0xF then 0x10
    for (int i = 2; i <= 15; i++) exp_q.push_back(32'(i));
    exp_q.push_back(32'h10);
    f_rd = 1'b1;
    while (exp_q.size() > 0) begin
      check("drain_order", f_d, exp_q.pop_front());
      step();
    end
    f_rd = 1'b0;
    check("drained_cnt", {28'd0, f_cnt}, 32'd0);
    check("drained_dv", {31'd0, f_dv}, 32'd0);

    // Sustained push+pop at count 1 for 100 cycles
    s_valid = 1'b1;
    s_data  = 32'h100;
    step();
    check("stream_start_cnt", {28'd0, f_cnt}, 32'd1);
    prev = 32'h100;
    f_rd = 1'b1;
    for (int i = 0; i < 100; i++) begin
      s_data = 32'h200 + 32'(i);
      check("stream_head", f_d, prev);
      step();
      check("stream_cnt", {28'd0, f_cnt}, 32'd1);
      prev = 32'h200 + 32'(i);
    end
    s_valid = 1'b0;
    f_rd    = 1'b0;
    check("stream_last_head", f_d, 32'h263);
    f_rd = 1'b1;
    step();
    f_rd = 1'b0;
    check("stream_empty_cnt", {28'd0, f_cnt}, 32'd0);

    // clr with simultaneous push and pop
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_data = 32'h50 + 32'(i);
      step();
    end
    check("pre_clr_cnt", {28'd0, f_cnt}, 32'd5);
    s_data = 32'h99;
    f_rd   = 1'b1;
    clr    = 1'b1;
    step();
    clr     = 1'b0;
    s_valid = 1'b0;
    f_rd    = 1'b0;
    check("clr_cnt", {28'd0, f_cnt}, 32'd0);
    check("clr_dv", {31'd0, f_dv}, 32'd0);
    check("clr_ready", {31'd0, s_ready}, 32'd0);
    step();
    check("post_clr_ready", {31'd0, s_ready}, 32'd1);
    s_valid = 1'b1;
    s_data  = 32'hAB;
    step();
    s_valid = 1'b0;
    check("post_clr_cnt", {28'd0, f_cnt}, 32'd1);
    check("post_clr_dv", {31'd0, f_dv}, 32'd1);
    check("post_clr_head", f_d, 32'hAB);

    // Idle with a partial fill
`ifdef WB_STREAM_FIFO_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      step();
      check("timeout_rise", {31'd0, f_timeout}, (k == 8) ? 32'd1 : 32'd0);
    end
`else
    for (int k = 1; k <= 12; k++) begin
      step();
      check("timeout_off", {31'd0, f_timeout}, 32'd0);
    end
`endif
    f_rd = 1'b1;
    step();
    f_rd = 1'b0;
    check("final_cnt", {28'd0, f_cnt}, 32'd0);
    check("final_dv", {31'd0, f_dv}, 32'd0);
    check("final_timeout", {31'd0, f_timeout}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
